// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch / writeback stage wrapped around the 8-bit ALU.
//
// Holds the register file and the condition bit (CB). It accepts instructions over a
// valid/ready handshake and registers their operands into the EX register that drives
// the ALU. At retire it writes the ALU result back, or latches the ALU zero flag into
// CB for slt/seq. When a dependent instruction issues in the same cycle, the in-flight
// result is forwarded to it.
//
// Optional build macro: ALU_OPSTAGE_R0_ZERO_EN
//   Defined   -> register 0 reads as zero on the operand and debug paths, writes to
//                rd=0 are dropped, and forwarding never matches rd=0.
//   Undefined -> register 0 is an ordinary writable register.

module alu_operand_stage #(
    parameter  int NREGS = 8,
    parameter  int DW    = 8,
    localparam int SW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          issue_valid_i,
    output logic          issue_ready_o,
    input  logic [2:0]    issue_op_i,
    input  logic [SW-1:0] rs_sel_i,
    input  logic [SW-1:0] rt_sel_i,
    input  logic [SW-1:0] rd_sel_i,
    input  logic          wb_en_i,
    input  logic          stall_i,
    output logic          ex_valid_o,
    output logic [2:0]    ex_opcode_o,
    output logic [DW-1:0] ex_rs_o,
    output logic [DW-1:0] ex_rt_o,
    input  logic [DW-1:0] alu_result_i,
    input  logic          alu_zero_i,
    output logic          cb_o,
    input  logic [SW-1:0] dbg_sel_i,
    output logic [DW-1:0] dbg_data_o
);

    // Compare opcodes update CB rather than the register file.
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SEQ = 3'b111;

    // Architectural state.
    logic [DW-1:0] r_regs [NREGS];
    logic          r_cb;

    // EX pipeline register.
    logic          r_ex_valid;
    logic [2:0]    r_ex_opcode;
    logic [SW-1:0] r_ex_rd;
    logic          r_ex_wb_en;
    logic [DW-1:0] r_ex_rs;
    logic [DW-1:0] r_ex_rt;

    // Handshake and retire qualifiers.
    logic          w_accept;
    logic          w_retire;
    logic          w_ex_is_cmp;
    logic          w_ex_writes;

    // Operand paths.
    logic [DW-1:0] w_rs_rf;
    logic [DW-1:0] w_rt_rf;
    logic [DW-1:0] w_rs_op;
    logic [DW-1:0] w_rt_op;
    logic [DW-1:0] w_dbg;

    // The stage can take a new instruction whenever EX is empty or is leaving this cycle.
    assign issue_ready_o = !r_ex_valid || !stall_i;
    assign w_accept      = issue_valid_i && issue_ready_o;
    assign w_retire      = r_ex_valid && !stall_i;
    assign w_ex_is_cmp   = (r_ex_opcode == OP_SLT) || (r_ex_opcode == OP_SEQ);

    // A retiring instruction writes the register file only if it is a non-compare
    // opcode with wb_en set; the same qualifier gates forwarding.
`ifdef ALU_OPSTAGE_R0_ZERO_EN
    assign w_ex_writes = w_retire && r_ex_wb_en && !w_ex_is_cmp && (r_ex_rd != '0);
`else
    assign w_ex_writes = w_retire && r_ex_wb_en && !w_ex_is_cmp;
`endif

    // Combinational register-file reads for both operands and the debug port.
    always_comb begin
        // NOTE: every output of a combinational block gets a value before any condition
        // can skip it; a path that leaves one unassigned would infer a latch.
        w_rs_rf = r_regs[rs_sel_i];
        w_rt_rf = r_regs[rt_sel_i];
        w_dbg   = r_regs[dbg_sel_i];
`ifdef ALU_OPSTAGE_R0_ZERO_EN
        if (rs_sel_i == '0) w_rs_rf = '0;
        if (rt_sel_i == '0) w_rt_rf = '0;
        if (dbg_sel_i == '0) w_dbg = '0;
`endif
    end

    // Forward the retiring result to each source independently when its select hits rd.
    always_comb begin
        w_rs_op = w_rs_rf;
        w_rt_op = w_rt_rf;
        if (w_ex_writes && (rs_sel_i == r_ex_rd)) w_rs_op = alu_result_i;
        if (w_ex_writes && (rt_sel_i == r_ex_rd)) w_rt_op = alu_result_i;
    end

    // Debug read shows committed state only; forwarding is deliberately bypassed.
    assign dbg_data_o = w_dbg;

    // Register file: cleared on reset, written at the retire edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // NOTE: the register file is an array, yet it is cleared here because every
            // architectural register must read zero after reset; this keeps it in flops
            // rather than a RAM macro, which is acceptable at 8x8 bits.
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ex_writes) begin
            // NOTE: state is updated with non-blocking assignments so every flop samples
            // the pre-edge values, independent of statement order.
            r_regs[r_ex_rd] <= alu_result_i;
        end
    end

    // EX register: load on accept, empty on retire without accept, hold while stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ex_valid  <= 1'b0;
            r_ex_opcode <= '0;
            r_ex_rd     <= '0;
            r_ex_wb_en  <= 1'b0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
        end else if (w_accept) begin
            r_ex_valid  <= 1'b1;
            r_ex_opcode <= issue_op_i;
            r_ex_rd     <= rd_sel_i;
            r_ex_wb_en  <= wb_en_i;
            r_ex_rs     <= w_rs_op;
            r_ex_rt     <= w_rt_op;
        end else if (w_retire) begin
            r_ex_valid  <= 1'b0;
        end
    end

    // Condition bit: latch the ALU zero flag when a compare retires, whatever wb_en says.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cb <= 1'b0;
        end else if (w_retire && w_ex_is_cmp) begin
            r_cb <= alu_zero_i;
        end
    end

    assign ex_valid_o  = r_ex_valid;
    assign ex_opcode_o = r_ex_opcode;
    assign ex_rs_o     = r_ex_rs;
    assign ex_rt_o     = r_ex_rt;
    assign cb_o        = r_cb;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch and writeback stage wrapped around the 8-bit ALU.
- Holds the 8x8-bit register file and the condition bit (CB). Accepts issued instructions through a valid/ready handshake and registers operands into an EX pipeline register that drives the ALU.
- Writes ALU results back and latches the ALU zero output into CB for slt/seq.
- Forwards the in-flight EX result to a back-to-back dependent instruction.

Parameters:
- NREGS, 8, register-file depth; select fields are log2(NREGS) = 3 bits wide.
- DW, 8, datapath width; must match the ALU.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- issue_valid_i  in  1  issue request.
- issue_ready_o  out  1  stage can accept.
- issue_op_i  in  3  ALU opcode.
- rs_sel_i  in  3  source A register.
- rt_sel_i  in  3  source B register.
- rd_sel_i  in  3  destination register.
- wb_en_i  in  1  write rd with the result.
- stall_i  in  1  hold the EX register.
- ex_valid_o  out  1  EX register holds a live instruction.
- ex_opcode_o  out  3  to ALU opcode_i.
- ex_rs_o  out  DW  to ALU rs_i.
- ex_rt_o  out  DW  to ALU rt_i.
- alu_result_i  in  DW  from ALU alu_result_o.
- alu_zero_i  in  1  from ALU zero.
- cb_o  out  1  condition bit, registered.
- dbg_sel_i  in  3  debug read select.
- dbg_data_o  out  DW  combinational read of regfile[dbg_sel_i].

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - All registers cleared to 0.
  - ex_valid_o=0, ex_opcode_o=0, ex_rs_o=0, ex_rt_o=0, cb_o=0.
  - Reset dominates any simultaneous accept, writeback or CB update; an in-flight EX instruction is discarded without writeback.
- Handshake:
  - issue_ready_o = !ex_valid_o | !stall_i (combinational).
  - Accept = issue_valid_i & issue_ready_o.
  - issue_* fields are sampled only on accept.
- EX register:
  - On accept, it loads opcode, rd, wb_en and the operands, and ex_valid_o goes 1 the next cycle (1-cycle issue-to-EX latency).
  - Operand read is combinational from the regfile in the accept cycle.
- Retire: occurs when ex_valid_o & !stall_i.
  - Retire without accept: ex_valid_o goes 0.
  - Retire with accept: the EX register is overwritten, with no bubble.
  - Stall: while ex_valid_o & stall_i, all EX outputs are held stable and there is no writeback or CB update.
- Writeback, at the retire edge:
  - Opcodes 000, 001, 010, 011, 100, 110 with wb_en: regfile[rd] <= alu_result_i.
  - Opcodes 101 (slt) and 111 (seq): cb_o <= alu_zero_i, regardless of wb_en; the regfile is unchanged.
  - wb_en with opcode 101 or 111 is ignored.
- Forwarding:
  - Applies when an accept coincides with a retiring EX instruction that writes a register.
  - For each source separately, if the select equals the EX rd, the operand is alu_result_i instead of the regfile value.
  - rs and rt may both forward.
  - No forwarding when the EX instruction does not write a register, or when it is stalled (no accept is possible then anyway).
- Arithmetic: none in this block; all values are DW bits and are passed unmodified.
- dbg_data_o reflects the committed regfile only, with no forwarding.

Optional Feature:
- Macro: ALU_OPSTAGE_R0_ZERO_EN.
- Defined:
  - Register 0 reads as 0 on operand and debug paths.
  - Writes with rd=0 are dropped; forwarding never matches rd=0.
  - cb_o is unaffected.
- Undefined: register 0 is an ordinary writable register.

Test Plan:
- Reset mid-stall: load r1=5, issue add, hold stall_i=1, assert rst_n_i=0 for 1 cycle -> ex_valid_o=0, cb_o=0, dbg r1=0, no writeback.
- Back-to-back forwarding:
  - Issue add r1=r2+r3 (r2=3, r3=4), then next cycle add r4=r1+r1 with no stall.
  - Required: second EX shows ex_rs_o=ex_rt_o=7, and r4 reads 14 after retire.
- Stall hold: issue sub, hold stall_i=1 for 3 cycles with issue_valid_i=1 -> issue_ready_o=0 throughout, EX outputs constant, one writeback only after stall_i drops.
- CB update: seq with r6=9, r7=9 and ALU zero=1 -> cb_o=1, regfile unchanged even with wb_en=1. Then slt with zero=0 -> cb_o=0.
- wb_en=0: and with rd=2 -> r2 unchanged; a following read of r2 is not forwarded.
- ALU_OPSTAGE_R0_ZERO_EN defined: add writing r0=0x55 -> dbg r0=0, and a dependent instruction issued next cycle reading r0 gets 0.
